cla_carry_stage: RTL and testbench

- Pipelined carry-lookahead front end of the adder datapath.
- Registers the operands and forms per-bit propagate/generate terms, then resolves every bit's carry-in by lookahead.
- Presents `p_o` and `ci_o` to the downstream per-bit sum stage, which computes `sum = p ^ ci`.
- Valid/ready handshake with a carry-chaining register, so operands wider than WIDTH can be added as a stream of WIDTH-bit beats.

---
 rtl/cla_carry_stage.sv | 144 ++++++++++++++
 tb/tb_cla_carry_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_carry_stage.sv
// cla_carry_stage: two-stage pipelined carry-lookahead front end.
// S1 registers per-bit propagate/generate terms; S2 resolves every bit's
// carry-in with a flattened lookahead and registers p_o/ci_o/cout_o.
// Optional feature macro: CLA_CHAIN_EN adds the chain port and a carry
// register so multi-beat operands can be added as a stream.
module cla_carry_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_CHAIN_EN
    input  logic             chain,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p_o,
    output logic [WIDTH-1:0] ci_o,
    output logic             cout_o
);

    // Flattened lookahead: each carry is one OR of product terms, so every
    // bit sees a single AND-OR level rather than a ripple chain.
    function automatic logic [WIDTH:0] lookahead(input logic [WIDTH-1:0] p,
                                                 input logic [WIDTH-1:0] g,
                                                 input logic             c0);
        logic [WIDTH:0] c;
        logic           term;
        c    = {(WIDTH+1){1'b0}};
        c[0] = c0;
        for (int i = 1; i <= WIDTH; i++) begin
            term = c0;
            for (int k = 0; k < i; k++) begin
                term = term & p[k];
            end
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & p[k];
                end
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    logic [WIDTH-1:0] s1_p_r;
    logic [WIDTH-1:0] s1_g_r;
    logic             s1_cin_r;
    logic             s1_valid_r;
    logic             cin_sel_s;
    logic             s2_adv_s;
    logic             accept_s;
    logic [WIDTH:0]   carry_s;

`ifdef CLA_CHAIN_EN
    logic             s1_chain_r;
    logic             carry_q_r;
`endif

    assign s2_adv_s = s1_valid_r & (~out_valid | out_ready);
    assign in_ready = ~s1_valid_r | s2_adv_s;
    assign accept_s = in_valid & in_ready;

    // Pick the carry into bit 0: previous beat's cout for chained beats.
    always_comb begin
        cin_sel_s = s1_cin_r;
`ifdef CLA_CHAIN_EN
        if (s1_chain_r) begin
            cin_sel_s = carry_q_r;
        end else begin
            cin_sel_s = s1_cin_r;
        end
`endif
    end

    // Resolve all carries from the S1 terms and the selected carry-in.
    always_comb begin
        carry_s = lookahead(s1_p_r, s1_g_r, cin_sel_s);
    end

    // S1: capture propagate/generate terms on accept, empty when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_p_r     <= {WIDTH{1'b0}};
            s1_g_r     <= {WIDTH{1'b0}};
            s1_cin_r   <= 1'b0;
            s1_valid_r <= 1'b0;
`ifdef CLA_CHAIN_EN
            s1_chain_r <= 1'b0;
`endif
        end else if (accept_s) begin
            s1_p_r     <= a ^ b;
            s1_g_r     <= a & b;
            s1_cin_r   <= cin;
            s1_valid_r <= 1'b1;
`ifdef CLA_CHAIN_EN
            s1_chain_r <= chain;
`endif
        end else if (s2_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // S2: register the resolved carries; hold data while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_o       <= {WIDTH{1'b0}};
            ci_o      <= {WIDTH{1'b0}};
            cout_o    <= 1'b0;
            out_valid <= 1'b0;
        end else if (s2_adv_s) begin
            p_o       <= s1_p_r;
            ci_o      <= carry_s[WIDTH-1:0];
            cout_o    <= carry_s[WIDTH];
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

`ifdef CLA_CHAIN_EN
    // Chaining register: cout of the most recent beat to leave S1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q_r <= 1'b0;
        end else if (s2_adv_s) begin
            carry_q_r <= carry_s[WIDTH];
        end else begin
            carry_q_r <= carry_q_r;
        end
    end
`endif

endmodule

// File: tb/tb_cla_carry_stage.sv
// Directed self-checking bench for cla_carry_stage (WIDTH = 4).
// Honours CLA_CHAIN_EN: the chain port and chaining tests appear only
// when the macro is defined.
module tb_cla_carry_stage;

    localparam int WIDTH = 4;
`ifdef CLA_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             chain;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] p_o;
    logic [WIDTH-1:0] ci_o;
    logic             cout_o;

    int checks = 0;
    int passes = 0;

    logic [WIDTH:0] exp_q[$];
    logic           model_carry;

    cla_carry_stage #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef CLA_CHAIN_EN
        .chain    (chain),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p_o      (p_o),
        .ci_o     (ci_o),
        .cout_o   (cout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; the scoreboard tracks accepted and consumed beats.
    task automatic tick(output bit acc);
        bit             cons;
        logic           csel;
        logic [WIDTH:0] e;
        @(negedge clk);
        acc  = in_valid & in_ready;
        cons = out_valid & out_ready;
        if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
            csel = (CHAIN_EN && chain) ? model_carry : cin;
            e = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, csel};
            model_carry = e[WIDTH];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 4'h0; b = 4'h0; cin = 1'b0; chain = 1'b0;
        exp_q.delete(); model_carry = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (p_o !== 4'h0 || ci_o !== 4'h0 || cout_o !== 1'b0)
            $display("FAIL reset_data got p=%h ci=%h co=%b want 0/0/0", p_o, ci_o, cout_o); else passes++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passes++;
    endtask

    task automatic test_single();
        bit acc;
        out_ready = 1'b1; in_valid = 1'b1; a = 4'hF; b = 4'h1; cin = 1'b0; chain = 1'b0;
        tick(acc);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL single_latency got out_valid=%b want 0", out_valid); else passes++;
        tick(acc);
        checks++; if (out_valid !== 1'b1 || p_o !== 4'hE || ci_o !== 4'hE || cout_o !== 1'b1)
            $display("FAIL single_beat got v=%b p=%h ci=%h co=%b want 1/E/E/1", out_valid, p_o, ci_o, cout_o);
        else passes++;
        tick(acc);
    endtask

    task automatic test_exhaustive();
        bit acc;
        logic [8:0] k9;
        out_ready = 1'b1; chain = 1'b0;
        for (int k = 0; k < 514; k++) begin
            k9 = k[8:0];
            in_valid = (k < 512);
            a = k9[3:0]; b = k9[7:4]; cin = k9[8];
            if (k < 512) begin
                checks++; if (in_ready !== 1'b1) $display("FAIL exh_in_ready beat %0d got %b want 1", k, in_ready); else passes++;
            end
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || exp_q.size() == 0 || {cout_o, p_o ^ ci_o} !== exp_q[0])
                    $display("FAIL exh_sum beat %0d got v=%b sum=%h want v=1 sum=%h", k - 2, out_valid,
                             {cout_o, p_o ^ ci_o}, (exp_q.size() > 0) ? exp_q[0] : 5'h0);
                else passes++;
            end
            tick(acc);
        end
        in_valid = 1'b0;
        tick(acc);
    endtask

`ifdef CLA_CHAIN_EN
    task automatic test_chain();
        bit acc;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 4'hF; b = 4'h1; cin = 1'b0; chain = 1'b0;
        tick(acc);
        a = 4'h0; b = 4'h0; cin = 1'b0; chain = 1'b1;
        tick(acc);
        in_valid = 1'b0; chain = 1'b0;
        checks++; if (out_valid !== 1'b1 || p_o !== 4'hE || ci_o !== 4'hE || cout_o !== 1'b1)
            $display("FAIL chain_beat1 got v=%b p=%h ci=%h co=%b want 1/E/E/1", out_valid, p_o, ci_o, cout_o);
        else passes++;
        tick(acc);
        checks++; if (out_valid !== 1'b1 || p_o !== 4'h0 || ci_o !== 4'h1 || cout_o !== 1'b0)
            $display("FAIL chain_beat2 got v=%b p=%h ci=%h co=%b want 1/0/1/0", out_valid, p_o, ci_o, cout_o);
        else passes++;
        tick(acc);
    endtask
`endif

    task automatic test_backpressure();
        bit acc;
        int got;
        int nacc;
        logic [WIDTH-1:0] va[3];
        logic [WIDTH-1:0] vb[3];
        logic             vc[3];
        logic [WIDTH-1:0] hp;
        logic [WIDTH-1:0] hc;
        logic             ho;
        va = '{4'h3, 4'h9, 4'h7}; vb = '{4'h4, 4'h9, 4'h8}; vc = '{1'b0, 1'b1, 1'b0};
        out_ready = 1'b0; chain = 1'b0; nacc = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = va[nacc]; b = vb[nacc]; cin = vc[nacc];
            tick(acc);
            if (acc) nacc++;
        end
        checks++; if (nacc !== 2) $display("FAIL bp_accepted got %0d want 2", nacc); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else passes++;
        hp = p_o; hc = ci_o; ho = cout_o;
        tick(acc);
        checks++; if (out_valid !== 1'b1 || p_o !== hp || ci_o !== hc || cout_o !== ho
                      || exp_q.size() == 0 || {cout_o, p_o ^ ci_o} !== exp_q[0])
            $display("FAIL bp_hold got v=%b p=%h ci=%h co=%b", out_valid, p_o, ci_o, cout_o);
        else passes++;
        out_ready = 1'b1; got = 0;
        for (int i = 0; i < 12 && got < 3; i++) begin
            if (nacc >= 3) in_valid = 1'b0;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0 || {cout_o, p_o ^ ci_o} !== exp_q[0])
                    $display("FAIL bp_order beat %0d got %h want %h", got, {cout_o, p_o ^ ci_o},
                             (exp_q.size() > 0) ? exp_q[0] : 5'h0);
                else passes++;
                got++;
            end
            tick(acc);
            if (acc) nacc++;
        end
        in_valid = 1'b0;
        checks++; if (got !== 3 || nacc !== 3 || exp_q.size() !== 0)
            $display("FAIL bp_count got out=%0d in=%0d left=%0d want 3/3/0", got, nacc, exp_q.size());
        else passes++;
    endtask

    task automatic test_reset_midstream();
        bit acc;
        out_ready = 1'b0; in_valid = 1'b1; a = 4'hF; b = 4'h1; cin = 1'b0; chain = 1'b0;
        tick(acc);
        tick(acc);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL mid_full got v=%b rdy=%b want 1/0", out_valid, in_ready); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || cout_o !== 1'b0)
            $display("FAIL mid_async got v=%b co=%b want 0/0", out_valid, cout_o); else passes++;
        exp_q.delete(); model_carry = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got %b want 1", in_ready); else passes++;
        out_ready = 1'b1; in_valid = 1'b1; a = 4'h0; b = 4'h0;
        chain = CHAIN_EN; cin = CHAIN_EN;
        tick(acc);
        in_valid = 1'b0; chain = 1'b0; cin = 1'b0;
        tick(acc);
        checks++; if (out_valid !== 1'b1 || ci_o[0] !== 1'b0 || p_o !== 4'h0)
            $display("FAIL mid_carry_clear got v=%b ci=%h p=%h want 1/0/0", out_valid, ci_o, p_o); else passes++;
        tick(acc);
    endtask

    task automatic test_toggle();
        bit acc;
        int nacc;
        int got;
        nacc = 0; got = 0; chain = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 60 && got < 8; i++) begin
            in_valid = (nacc < 8);
            a = 4'(nacc * 5 + 3); b = 4'(nacc * 3 + 9); cin = nacc[0];
            out_ready = ~out_ready;
            #1;
            if (exp_q.size() == 2) begin
                checks++; if (in_ready !== out_ready)
                    $display("FAIL tog_in_ready got %b want %b", in_ready, out_ready); else passes++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0 || {cout_o, p_o ^ ci_o} !== exp_q[0])
                    $display("FAIL tog_sum beat %0d got %h want %h", got, {cout_o, p_o ^ ci_o},
                             (exp_q.size() > 0) ? exp_q[0] : 5'h0);
                else passes++;
                got++;
            end
            tick(acc);
            if (acc) nacc++;
        end
        in_valid = 1'b0;
        checks++; if (got !== 8 || nacc !== 8)
            $display("FAIL tog_count got out=%0d in=%0d want 8/8", got, nacc); else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_exhaustive();
`ifdef CLA_CHAIN_EN
        test_chain();
`endif
        test_backpressure();
        test_reset_midstream();
        test_toggle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
